// File: rtl/simon_draw_pkg.sv
// Shared constants, state encoding and colour helper for the rectangle plot engine.
package simon_draw_pkg;

  localparam int SCREEN_W     = 160;
  localparam int SCREEN_H     = 120;
  localparam int QUAD_W       = 80;
  localparam int QUAD_H       = 60;
  localparam int CURSOR_SIZE  = 8;
  localparam int CURSOR_STEP  = 4;
  localparam int CURSOR_MAX_X = 152;
  localparam int CURSOR_MAX_Y = 112;
  localparam int CURSOR_RST_X = 72;
  localparam int CURSOR_RST_Y = 52;

  localparam logic [2:0] COL_Q_TL   = 3'd1;
  localparam logic [2:0] COL_Q_TR   = 3'd2;
  localparam logic [2:0] COL_Q_BL   = 3'd4;
  localparam logic [2:0] COL_Q_BR   = 3'd6;
  localparam logic [2:0] COL_CURSOR = 3'd7;

  localparam logic [1:0] DIR_RIGHT = 2'b00;
  localparam logic [1:0] DIR_LEFT  = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_UP    = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FILL   = 3'd1,
    S_CDRAW  = 3'd2,
    S_CERASE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  // Background colour of the quarter a pixel falls in; erase restores this.
  function automatic logic [2:0] quarter_colour(input logic [8:0] x, input logic [7:0] y);
    if (y < 8'(QUAD_H))
      return (x < 9'(QUAD_W)) ? COL_Q_TL : COL_Q_TR;
    else
      return (x < 9'(QUAD_W)) ? COL_Q_BL : COL_Q_BR;
  endfunction

endpackage

// File: rtl/rect_scan_counter.sv
// Raster offset generator: X inner, Y outer; last flags the final pixel of the rectangle.
module rect_scan_counter #(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 8,
  parameter int XW     = $clog2(WIDTH),
  parameter int YW     = $clog2(HEIGHT)
) (
  input  logic          CLOCK_50,
  input  logic          resetn,
  input  logic          start,
  input  logic          en,
  output logic [XW-1:0] offX,
  output logic [YW-1:0] offY,
  output logic          last
);

  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

  assign last = (offX == X_LAST) && (offY == Y_LAST);

  always_ff @(posedge CLOCK_50) begin
    if (!resetn || start) begin
      offX <= '0;
      offY <= '0;
    end else if (en) begin
      if (offX == X_LAST) begin
        offX <= '0;
        offY <= (offY == Y_LAST) ? '0 : offY + 1'b1;
      end else begin
        offX <= offX + 1'b1;
      end
    end
  end

endmodule

// File: rtl/rect_plot_engine.sv
// Quarter-fill and 8x8 cursor draw/erase engine feeding a VGA adapter, one pixel per clock.
module rect_plot_engine
  import simon_draw_pkg::*;
(
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic [7:0] inX,
  input  logic [6:0] inY,
  input  logic [2:0] inColour,
  input  logic       fill_req,
  input  logic       load,
  input  logic       draw,
  input  logic       erase,
  input  logic       move,
  input  logic [1:0] dir,
  output logic [7:0] vgaX,
  output logic [6:0] vgaY,
  output logic [2:0] vgaColour,
  output logic       plot,
  output logic       done,
  output logic       busy
);

  // state    | meaning
  // S_IDLE   | accept one command per cycle (load > move > erase > draw > fill_req)
  // S_FILL   | scanning the 80x60 fill rectangle
  // S_CDRAW  | scanning the 8x8 cursor in cursor colour
  // S_CERASE | scanning the 8x8 cursor in its background quarter colours
  // S_DONE   | single-cycle completion pulse

  state_t     state;
  logic [7:0] cur_x, fill_x;
  logic [6:0] cur_y, fill_y;
  logic [2:0] fill_col;

  logic [6:0] fill_ox;
  logic [5:0] fill_oy;
  logic       fill_last;
  logic [2:0] cur_ox, cur_oy;
  logic       cur_last;

  logic idle, fill_start, cur_start, scanning, on_screen;
  logic [8:0] px;
  logic [7:0] py;
  logic [2:0] pix_col;

  assign idle       = (state == S_IDLE);
  assign cur_start  = idle && !load && !move && (erase || draw);
  assign fill_start = idle && !load && !move && !erase && !draw && fill_req;

  rect_scan_counter #(.WIDTH(QUAD_W), .HEIGHT(QUAD_H)) u_fill_scan (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .start    (fill_start),
    .en       (state == S_FILL),
    .offX     (fill_ox),
    .offY     (fill_oy),
    .last     (fill_last)
  );

  rect_scan_counter #(.WIDTH(CURSOR_SIZE), .HEIGHT(CURSOR_SIZE)) u_cursor_scan (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .start    (cur_start),
    .en       ((state == S_CDRAW) || (state == S_CERASE)),
    .offX     (cur_ox),
    .offY     (cur_oy),
    .last     (cur_last)
  );

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state    <= S_IDLE;
      cur_x    <= 8'(CURSOR_RST_X);
      cur_y    <= 7'(CURSOR_RST_Y);
      fill_x   <= '0;
      fill_y   <= '0;
      fill_col <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (load) begin
            cur_x <= (inX > 8'(CURSOR_MAX_X)) ? 8'(CURSOR_MAX_X) : inX;
            cur_y <= (inY > 7'(CURSOR_MAX_Y)) ? 7'(CURSOR_MAX_Y) : inY;
          end else if (move) begin
            unique case (dir)
              DIR_RIGHT: cur_x <= (cur_x >= 8'(CURSOR_MAX_X - CURSOR_STEP)) ?
                                  8'(CURSOR_MAX_X) : cur_x + 8'(CURSOR_STEP);
              DIR_LEFT:  cur_x <= (cur_x < 8'(CURSOR_STEP)) ? '0 : cur_x - 8'(CURSOR_STEP);
              DIR_DOWN:  cur_y <= (cur_y >= 7'(CURSOR_MAX_Y - CURSOR_STEP)) ?
                                  7'(CURSOR_MAX_Y) : cur_y + 7'(CURSOR_STEP);
              default:   cur_y <= (cur_y < 7'(CURSOR_STEP)) ? '0 : cur_y - 7'(CURSOR_STEP);
            endcase
          end else if (erase) begin
            state <= S_CERASE;
          end else if (draw) begin
            state <= S_CDRAW;
          end else if (fill_req) begin
            state    <= S_FILL;
            fill_x   <= inX;
            fill_y   <= inY;
            fill_col <= inColour;
          end
        end
        S_FILL:   if (fill_last) state <= S_DONE;
        S_CDRAW:  if (cur_last)  state <= S_DONE;
        S_CERASE: if (cur_last)  state <= S_DONE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  // Off-screen pixels still consume a scan cycle; only the strobe is suppressed.
  always_comb begin
    if (state == S_FILL) begin
      px = 9'(fill_x) + 9'(fill_ox);
      py = 8'(fill_y) + 8'(fill_oy);
    end else begin
      px = 9'(cur_x) + 9'(cur_ox);
      py = 8'(cur_y) + 8'(cur_oy);
    end
  end

  always_comb begin
    unique case (state)
      S_FILL:   pix_col = fill_col;
      S_CDRAW:  pix_col = COL_CURSOR;
      S_CERASE: pix_col = quarter_colour(px, py);
      default:  pix_col = '0;
    endcase
  end

  assign scanning  = (state == S_FILL) || (state == S_CDRAW) || (state == S_CERASE);
  assign on_screen = (px < 9'(SCREEN_W)) && (py < 8'(SCREEN_H));

  assign plot      = scanning && on_screen;
  assign vgaX      = plot ? px[7:0] : '0;
  assign vgaY      = plot ? py[6:0] : '0;
  assign vgaColour = plot ? pix_col : '0;
  assign done      = (state == S_DONE);
  assign busy      = !idle;

endmodule

// File: doc/rect_plot_engine.md
RECT_PLOT_ENGINE -- requirements
Module: rect_plot_engine

Interface
REQ-001 SHALL have port CLOCK_50, input, 1 bit: clock; all state changes on its rising edge.
REQ-002 SHALL have port resetn, input, 1 bit: reset, synchronous, active-low; clock CLOCK_50.
REQ-003 SHALL have port inX, input, 8 bits: fill origin X, or cursor X for load.
REQ-004 SHALL have port inY, input, 7 bits: fill origin Y, or cursor Y for load.
REQ-005 SHALL have port inColour, input, 3 bits: fill colour.
REQ-006 SHALL have port fill_req, input, 1 bit: level request to fill an 80x60 quarter at (inX,inY).
REQ-007 SHALL have ports load, draw, erase, move, input, 1 bit each: cursor commands.
REQ-008 SHALL have port dir, input, 2 bits: move direction; 00 right, 01 left, 10 down, 11 up.
REQ-009 SHALL have port vgaX, output, 8 bits: pixel X to the VGA adapter.
REQ-010 SHALL have port vgaY, output, 7 bits: pixel Y to the VGA adapter.
REQ-011 SHALL have port vgaColour, output, 3 bits: pixel colour.
REQ-012 SHALL have port plot, output, 1 bit: write strobe for the VGA adapter.
REQ-013 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-014 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-015 SHALL implement states IDLE, FILL, CDRAW, CERASE and DONE.
REQ-016 In IDLE, SHALL accept at most one command per cycle, priority load > move > erase > draw > fill_req.
REQ-017 load SHALL set the cursor to (min(inX,152), min(inY,112)) in one cycle, stay in IDLE and give no done.
REQ-018 move SHALL step the cursor 4 px in direction dir in one cycle, saturating at X 0..152 and Y 0..112, with no done.
REQ-019 fill_req SHALL latch inX/inY/inColour, enter FILL and scan 80x60 pixels, X inner and Y outer, one pixel per cycle.
REQ-020 draw SHALL enter CDRAW and scan the 8x8 cursor at the cursor position in colour 3'd7.
REQ-021 erase SHALL enter CERASE and scan the 8x8 cursor area, writing each pixel in its quarter colour.
REQ-022 Quarter colours SHALL be: x<80,y<60 -> 1; x>=80,y<60 -> 2; x<80,y>=60 -> 4; otherwise -> 6.
REQ-023 Timing: for a command accepted at edge N, plot SHALL be high from cycle N+1 through N+P, where P is 4800 for a fill and 64 for draw/erase.
REQ-024 done SHALL be high only in cycle N+P+1 (state DONE), after which the engine SHALL return to IDLE.
REQ-025 vgaX/vgaY SHALL equal origin+offset, computed in 9/8 bits; a pixel with X>=160 or Y>=120 SHALL have plot low, and the scan length SHALL be unchanged.
REQ-026 Commands arriving while busy SHALL be ignored (not queued).
REQ-027 If fill_req is still high in IDLE after DONE, a new fill SHALL start using the current inputs.
REQ-028 When plot is low, vgaX, vgaY and vgaColour SHALL be 0.

Reset
REQ-029 When resetn=0 at a clock edge: state IDLE; vgaX, vgaY, vgaColour, plot, done and busy all 0; cursor set to (72,52).
REQ-030 Reset mid-scan SHALL abort the scan, with no done pulse and no further plot.

Structure
REQ-031 Package simon_draw_pkg SHALL hold: screen 160x120, quarter 80x60, cursor size 8, step 4, cursor limits 152/112, reset cursor (72,52), colour constants, and the state enum.
REQ-032 Scanning SHALL use one sub-module, rect_scan_counter, with parameters width/height and ports start, offX, offY, last.

Verification
REQ-033 Fill: inX=80, inY=0, inColour=2, fill_req pulsed -> 4800 plots covering X 80..159, Y 0..59 in colour 2, then one done pulse.
REQ-034 Cursor: after reset, draw -> 64 plots covering X 72..79, Y 52..59 in colour 7; done at cycle 65.
REQ-035 Erase straddling quarters: cursor at (76,56), erase -> pixel (79,59)=1, (80,59)=2, (79,60)=4, (83,63)=6.
REQ-036 Saturation: load (200,100) -> cursor (152,100); move right -> stays at X 152; move down x4 -> Y 112.
REQ-037 Robustness: fill_req and draw raised together -> draw wins; a second command while busy is ignored; resetn low mid-fill -> plot low next cycle and no done.
REQ-038 Clipping: fill at (120,90) -> plot only for X<160 and Y<120; done still at cycle 4801.
